// File: rtl/lcd_nibble_receiver_if.sv
// Four-bit HD44780 LCD bus as seen between a driver and the panel.
// master: drives sf_e/e/rs/rw/nibble, reads rd_nibble; slave: the panel side.
interface lcd_nibble_receiver_if;
  logic       sf_e;
  logic       e;
  logic       rs;
  logic       rw;
  logic [3:0] nibble;
  logic [3:0] rd_nibble;

  modport master (
    output sf_e, e, rs, rw, nibble,
    input  rd_nibble
  );

  modport slave (
    input  sf_e, e, rs, rw, nibble,
    output rd_nibble
  );
endinterface

// File: rtl/lcd_nibble_receiver.sv
// HD44780-style LCD controller model: receives the 4-bit bus, decodes
// instructions, tracks cursor/flags, reports char writes, busy and reads.
// Ports: clk, rst_n (sync, active low), bus (slave: strobes in, rd_nibble
// out), char_valid/char_data/char_addr, cur_addr, mode4, disp_on,
// cursor_on, blink_on, inc_dir, clr_pulse, busy, err_overrun.
module lcd_nibble_receiver #(
  parameter int unsigned BUSY_CYCLES = 2000,
  parameter int unsigned CLR_CYCLES  = 82000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lcd_nibble_receiver_if.slave bus,
  output logic                 char_valid,
  output logic [7:0]           char_data,
  output logic [6:0]           char_addr,
  output logic [6:0]           cur_addr,
  output logic                 mode4,
  output logic                 disp_on,
  output logic                 cursor_on,
  output logic                 blink_on,
  output logic                 inc_dir,
  output logic                 clr_pulse,
  output logic                 busy,
  output logic                 err_overrun
);

  typedef enum logic {
    MODE8,
    MODE4
  } mode_e;

  localparam logic [CNT_W-1:0] BUSY_LD = CNT_W'(BUSY_CYCLES);
  localparam logic [CNT_W-1:0] CLR_LD  = CNT_W'(CLR_CYCLES);

  // input synchronizers; e_s3 is the extra stage for edge detect
  logic       e_s1_q, e_s2_q, e_s3_q;
  logic       sf_s1_q, sf_s2_q;
  logic       rs_s1_q, rs_s2_q;
  logic       rw_s1_q, rw_s2_q;
  logic [3:0] nib_s1_q, nib_s2_q;

  mode_e      mode_q, mode_d;
  logic       phase_q, phase_d;
  logic       rd_phase_q, rd_phase_d;
  logic [3:0] hold_nib_q, hold_nib_d;
  logic       hold_rs_q, hold_rs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       char_valid_q, char_valid_d;
  logic [7:0] char_data_q, char_data_d;
  logic [6:0] char_addr_q, char_addr_d;
  logic [6:0] cur_addr_q, cur_addr_d;
  logic       disp_on_q, disp_on_d;
  logic       cursor_on_q, cursor_on_d;
  logic       blink_on_q, blink_on_d;
  logic       inc_dir_q, inc_dir_d;
  logic       clr_pulse_q, clr_pulse_d;
  logic [3:0] rd_nibble_q, rd_nibble_d;
  logic       err_q, err_d;

  logic       strobe;
  logic       busy_now;
  logic [7:0] wr_byte;

  // two-line DDRAM map: 0x00-0x27 and 0x40-0x67
  function automatic logic [6:0] step_addr(
    input logic [6:0] a,
    input logic       inc
  );
    if (inc) begin
      if (a == 7'h27)      return 7'h40;
      else if (a == 7'h67) return 7'h00;
      else                 return a + 7'd1;
    end else begin
      if (a == 7'h00)      return 7'h67;
      else if (a == 7'h40) return 7'h27;
      else                 return a - 7'd1;
    end
  endfunction

  assign strobe   = e_s3_q & ~e_s2_q & sf_s2_q;
  assign busy_now = (cnt_q != '0);
  assign wr_byte  = {hold_nib_q, nib_s2_q};

  always_comb begin
    mode_d       = mode_q;
    phase_d      = phase_q;
    rd_phase_d   = rd_phase_q;
    hold_nib_d   = hold_nib_q;
    hold_rs_d    = hold_rs_q;
    cnt_d        = busy_now ? cnt_q - 1'b1 : cnt_q;
    char_valid_d = 1'b0;
    char_data_d  = char_data_q;
    char_addr_d  = char_addr_q;
    cur_addr_d   = cur_addr_q;
    disp_on_d    = disp_on_q;
    cursor_on_d  = cursor_on_q;
    blink_on_d   = blink_on_q;
    inc_dir_d    = inc_dir_q;
    clr_pulse_d  = 1'b0;
    rd_nibble_d  = rd_nibble_q;
    err_d        = err_q;

    if (strobe && rw_s2_q) begin
      rd_phase_d  = ~rd_phase_q;
      rd_nibble_d = rd_phase_q ? cur_addr_q[3:0]
                               : {busy_now, cur_addr_q[6:4]};
    end else if (strobe) begin
      rd_phase_d = 1'b0;
      if (busy_now) err_d = 1'b1;
      if (mode_q == MODE8) begin
        // only function set to 4-bit (upper nibble 0x2) matters here
        if (!rs_s2_q && nib_s2_q == 4'h2) begin
          mode_d  = MODE4;
          phase_d = 1'b0;
        end
      end else if (!phase_q) begin
        hold_nib_d = nib_s2_q;
        hold_rs_d  = rs_s2_q;
        phase_d    = 1'b1;
      end else begin
        phase_d = 1'b0;
        cnt_d   = BUSY_LD;
        if (hold_rs_q) begin
          char_valid_d = 1'b1;
          char_data_d  = wr_byte;
          char_addr_d  = cur_addr_q;
          cur_addr_d   = step_addr(cur_addr_q, inc_dir_q);
        end else begin
          unique case (1'b1)
            wr_byte[7]: begin
              cur_addr_d = wr_byte[6:0];
            end
            wr_byte[7:6] == 2'b01: begin
            end
            wr_byte[7:6] == 2'b00 && wr_byte[5:4] != 2'b00: begin
            end
            wr_byte[7:3] == 5'b00001: begin
              disp_on_d   = wr_byte[2];
              cursor_on_d = wr_byte[1];
              blink_on_d  = wr_byte[0];
            end
            wr_byte[7:2] == 6'b000001: begin
              inc_dir_d = wr_byte[1];
            end
            wr_byte[7:1] == 7'b0000001: begin
              cur_addr_d = 7'h00;
              cnt_d      = CLR_LD;
            end
            wr_byte == 8'h01: begin
              cur_addr_d  = 7'h00;
              inc_dir_d   = 1'b1;
              clr_pulse_d = 1'b1;
              cnt_d       = CLR_LD;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_s1_q       <= 1'b0;
      e_s2_q       <= 1'b0;
      e_s3_q       <= 1'b0;
      sf_s1_q      <= 1'b0;
      sf_s2_q      <= 1'b0;
      rs_s1_q      <= 1'b0;
      rs_s2_q      <= 1'b0;
      rw_s1_q      <= 1'b0;
      rw_s2_q      <= 1'b0;
      nib_s1_q     <= 4'h0;
      nib_s2_q     <= 4'h0;
      mode_q       <= MODE8;
      phase_q      <= 1'b0;
      rd_phase_q   <= 1'b0;
      hold_nib_q   <= 4'h0;
      hold_rs_q    <= 1'b0;
      cnt_q        <= '0;
      char_valid_q <= 1'b0;
      char_data_q  <= 8'h00;
      char_addr_q  <= 7'h00;
      cur_addr_q   <= 7'h00;
      disp_on_q    <= 1'b0;
      cursor_on_q  <= 1'b0;
      blink_on_q   <= 1'b0;
      inc_dir_q    <= 1'b1;
      clr_pulse_q  <= 1'b0;
      rd_nibble_q  <= 4'h0;
      err_q        <= 1'b0;
    end else begin
      e_s1_q       <= bus.e;
      e_s2_q       <= e_s1_q;
      e_s3_q       <= e_s2_q;
      sf_s1_q      <= bus.sf_e;
      sf_s2_q      <= sf_s1_q;
      rs_s1_q      <= bus.rs;
      rs_s2_q      <= rs_s1_q;
      rw_s1_q      <= bus.rw;
      rw_s2_q      <= rw_s1_q;
      nib_s1_q     <= bus.nibble;
      nib_s2_q     <= nib_s1_q;
      mode_q       <= mode_d;
      phase_q      <= phase_d;
      rd_phase_q   <= rd_phase_d;
      hold_nib_q   <= hold_nib_d;
      hold_rs_q    <= hold_rs_d;
      cnt_q        <= cnt_d;
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
      char_addr_q  <= char_addr_d;
      cur_addr_q   <= cur_addr_d;
      disp_on_q    <= disp_on_d;
      cursor_on_q  <= cursor_on_d;
      blink_on_q   <= blink_on_d;
      inc_dir_q    <= inc_dir_d;
      clr_pulse_q  <= clr_pulse_d;
      rd_nibble_q  <= rd_nibble_d;
      err_q        <= err_d;
    end
  end

  assign char_valid    = char_valid_q;
  assign char_data     = char_data_q;
  assign char_addr     = char_addr_q;
  assign cur_addr      = cur_addr_q;
  assign mode4         = (mode_q == MODE4);
  assign disp_on       = disp_on_q;
  assign cursor_on     = cursor_on_q;
  assign blink_on      = blink_on_q;
  assign inc_dir       = inc_dir_q;
  assign clr_pulse     = clr_pulse_q;
  assign busy          = busy_now;
  assign err_overrun   = err_q;
  assign bus.rd_nibble = rd_nibble_q;

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Directed bench for lcd_nibble_receiver: vector table plus
// hand-written sequences for clear timing, reads, overrun and reset.
module tb_lcd_nibble_receiver;

  localparam int BUSY_N = 40;
  localparam int CLR_N  = 120;

  logic       clk;
  logic       rst_n;
  logic       char_valid;
  logic [7:0] char_data;
  logic [6:0] char_addr;
  logic [6:0] cur_addr;
  logic       mode4;
  logic       disp_on;
  logic       cursor_on;
  logic       blink_on;
  logic       inc_dir;
  logic       clr_pulse;
  logic       busy;
  logic       err_overrun;

  lcd_nibble_receiver_if bus ();

  lcd_nibble_receiver #(
    .BUSY_CYCLES(BUSY_N),
    .CLR_CYCLES (CLR_N),
    .CNT_W      (17)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_addr  (char_addr),
    .cur_addr   (cur_addr),
    .mode4      (mode4),
    .disp_on    (disp_on),
    .cursor_on  (cursor_on),
    .blink_on   (blink_on),
    .inc_dir    (inc_dir),
    .clr_pulse  (clr_pulse),
    .busy       (busy),
    .err_overrun(err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [3:0] nib;
    logic       m4;
    logic       bsy;
    logic [6:0] addr;
    logic [2:0] dcb;
    logic       inc;
    logic       idle;
  } vec_t;

  vec_t        tv[$];
  logic [14:0] cq[$];
  int          clr_cnt;
  int          bcount;
  int          checks;
  int          failures;

  always @(negedge clk) begin
    if (char_valid) cq.push_back({char_data, char_addr});
    if (clr_pulse) clr_cnt++;
    if (busy) bcount++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input int rs, input int nib, input int m4,
                     input int bsy, input int addr, input int dcb,
                     input int inc, input int idle);
    vec_t v;
    v.rs   = rs[0];
    v.nib  = nib[3:0];
    v.m4   = m4[0];
    v.bsy  = bsy[0];
    v.addr = addr[6:0];
    v.dcb  = dcb[2:0];
    v.inc  = inc[0];
    v.idle = idle[0];
    tv.push_back(v);
  endtask

  task automatic strobe(input logic sf, input logic r_s,
                        input logic r_w, input logic [3:0] n);
    @(negedge clk);
    bus.sf_e   = sf;
    bus.rs     = r_s;
    bus.rw     = r_w;
    bus.nibble = n;
    bus.e      = 1'b1;
    repeat (3) @(negedge clk);
    bus.e = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", int'(busy), 0);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      strobe(1'b1, tv[i].rs, 1'b0, tv[i].nib);
      chk($sformatf("r%0d_mode4", i), int'(mode4), int'(tv[i].m4));
      chk($sformatf("r%0d_busy", i), int'(busy), int'(tv[i].bsy));
      chk($sformatf("r%0d_addr", i), int'(cur_addr), int'(tv[i].addr));
      chk($sformatf("r%0d_dcb", i),
          int'({disp_on, cursor_on, blink_on}), int'(tv[i].dcb));
      chk($sformatf("r%0d_inc", i), int'(inc_dir), int'(tv[i].inc));
      if (tv[i].idle) wait_idle();
    end
  endtask

  logic [14:0] exp_ch[7];

  initial begin
    checks   = 0;
    failures = 0;
    clr_cnt  = 0;
    bcount   = 0;
    bus.sf_e   = 1'b0;
    bus.e      = 1'b0;
    bus.rs     = 1'b0;
    bus.rw     = 1'b0;
    bus.nibble = 4'h0;
    rst_n      = 1'b0;

    exp_ch[0] = {8'h48, 7'h00};
    exp_ch[1] = {8'h65, 7'h01};
    exp_ch[2] = {8'h58, 7'h40};
    exp_ch[3] = {8'h58, 7'h27};
    exp_ch[4] = {8'h41, 7'h00};
    exp_ch[5] = {8'h42, 7'h40};
    exp_ch[6] = {8'h43, 7'h7F};

    // rs nib m4 busy addr dcb inc idle
    add(0, 'h3, 0, 0, 'h00, 0, 1, 0);
    add(0, 'h3, 0, 0, 'h00, 0, 1, 0);
    add(0, 'h3, 0, 0, 'h00, 0, 1, 0);
    add(0, 'h2, 1, 0, 'h00, 0, 1, 0);
    add(0, 'h0, 1, 0, 'h00, 0, 1, 0);
    add(0, 'hC, 1, 1, 'h00, 4, 1, 1);
    add(0, 'h0, 1, 0, 'h00, 4, 1, 0);
    add(0, 'h6, 1, 1, 'h00, 4, 1, 1);
    add(1, 'h4, 1, 0, 'h00, 4, 1, 0);
    add(1, 'h8, 1, 1, 'h01, 4, 1, 1);
    add(1, 'h6, 1, 0, 'h01, 4, 1, 0);
    add(1, 'h5, 1, 1, 'h02, 4, 1, 1);
    add(0, 'hC, 1, 0, 'h02, 4, 1, 0);
    add(0, 'h0, 1, 1, 'h40, 4, 1, 1);
    add(0, 'hA, 1, 0, 'h41, 4, 1, 0);
    add(0, 'h7, 1, 1, 'h27, 4, 1, 1);
    add(1, 'h5, 1, 0, 'h27, 4, 1, 0);
    add(1, 'h8, 1, 1, 'h40, 4, 1, 1);
    add(0, 'h0, 1, 0, 'h40, 4, 1, 0);
    add(0, 'h4, 1, 1, 'h40, 4, 0, 1);
    add(0, 'h8, 1, 0, 'h40, 4, 0, 0);
    add(0, 'h0, 1, 1, 'h00, 4, 0, 1);
    add(1, 'h4, 1, 0, 'h00, 4, 0, 0);
    add(1, 'h1, 1, 1, 'h67, 4, 0, 1);
    add(0, 'hC, 1, 0, 'h67, 4, 0, 0);
    add(0, 'h0, 1, 1, 'h40, 4, 0, 1);
    add(1, 'h4, 1, 0, 'h40, 4, 0, 0);
    add(1, 'h2, 1, 1, 'h27, 4, 0, 1);
    add(0, 'hF, 1, 0, 'h27, 4, 0, 0);
    add(0, 'hF, 1, 1, 'h7F, 4, 0, 1);
    add(1, 'h4, 1, 0, 'h7F, 4, 0, 0);
    add(1, 'h3, 1, 1, 'h7E, 4, 0, 1);
    add(0, 'h0, 1, 0, 'h7E, 4, 0, 0);
    add(0, 'h2, 1, 1, 'h00, 4, 0, 1);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_char_valid", int'(char_valid), 0);
    chk("rst_char_data", int'(char_data), 0);
    chk("rst_addr", int'(cur_addr), 0);
    chk("rst_mode4", int'(mode4), 0);
    chk("rst_dcb", int'({disp_on, cursor_on, blink_on}), 0);
    chk("rst_inc", int'(inc_dir), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd", int'(bus.rd_nibble), 0);
    chk("rst_err", int'(err_overrun), 0);

    run_rows(0, 7);

    // clear display: one pulse, busy for exactly CLR_N cycles
    bcount = 0;
    strobe(1'b1, 1'b0, 1'b0, 4'h0);
    strobe(1'b1, 1'b0, 1'b0, 4'h1);
    chk("clr_pulse_cnt", clr_cnt, 1);
    chk("clr_busy", int'(busy), 1);
    chk("clr_addr", int'(cur_addr), 0);
    wait_idle();
    chk("clr_busy_len", bcount, CLR_N);

    run_rows(8, 13);

    // reads between the halves of a data byte
    strobe(1'b1, 1'b1, 1'b0, 4'h5);
    strobe(1'b1, 1'b0, 1'b1, 4'h0);
    chk("rd0_hi", int'(bus.rd_nibble), 'h4);
    strobe(1'b1, 1'b0, 1'b1, 4'h0);
    chk("rd0_lo", int'(bus.rd_nibble), 'h0);
    strobe(1'b1, 1'b0, 1'b1, 4'h0);
    chk("rd0_hi2", int'(bus.rd_nibble), 'h4);
    strobe(1'b1, 1'b1, 1'b0, 4'h8);
    chk("rd_split_addr", int'(cur_addr), 'h41);
    strobe(1'b1, 1'b0, 1'b1, 4'h0);
    chk("rd_busy_hi", int'(bus.rd_nibble), 'hC);
    strobe(1'b1, 1'b0, 1'b1, 4'h0);
    chk("rd_busy_lo", int'(bus.rd_nibble), 'h1);
    chk("err_before", int'(err_overrun), 0);
    strobe(1'b1, 1'b0, 1'b0, 4'h0);
    chk("err_set", int'(err_overrun), 1);
    strobe(1'b1, 1'b0, 1'b0, 4'hC);
    chk("err_disp", int'(disp_on), 1);
    chk("err_busy", int'(busy), 1);
    wait_idle();
    chk("err_sticky", int'(err_overrun), 1);

    run_rows(14, 33);

    // strobes with sf_e low are invisible
    strobe(1'b0, 1'b0, 1'b0, 4'h8);
    strobe(1'b0, 1'b0, 1'b0, 4'h5);
    strobe(1'b0, 1'b1, 1'b0, 4'h4);
    chk("sf_addr", int'(cur_addr), 0);
    chk("sf_busy", int'(busy), 0);
    strobe(1'b1, 1'b0, 1'b0, 4'h8);
    strobe(1'b1, 1'b0, 1'b0, 4'h5);
    chk("sf_phase_addr", int'(cur_addr), 'h05);
    wait_idle();

    // reset between halves
    strobe(1'b1, 1'b0, 1'b0, 4'h8);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_mode4", int'(mode4), 0);
    chk("rst2_addr", int'(cur_addr), 0);
    chk("rst2_dcb", int'({disp_on, cursor_on, blink_on}), 0);
    chk("rst2_inc", int'(inc_dir), 1);
    chk("rst2_err", int'(err_overrun), 0);
    strobe(1'b1, 1'b0, 1'b0, 4'h2);
    chk("rst2_mode4_on", int'(mode4), 1);
    strobe(1'b1, 1'b0, 1'b0, 4'h8);
    strobe(1'b1, 1'b0, 1'b0, 4'h3);
    chk("rst2_phase_addr", int'(cur_addr), 'h03);

    chk("char_count", cq.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < cq.size())
        chk($sformatf("char%0d", i), int'(cq[i]), int'(exp_ch[i]));
    end
    chk("clr_total", clr_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
